// File: rtl/hangman_pkg.sv
// Shared types and constants for the Hangman round controller and its letter tracker.
package hangman_pkg;

  localparam int LETTER_W = 5;
  localparam int ALPHA    = 26;
  localparam logic [ALPHA-1:0] ALL_LETTERS = 26'h3FFFFFF;

  typedef logic [LETTER_W-1:0] letter_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PLAY  = 3'd2,
    S_CHECK = 3'd3,
    S_EVAL  = 3'd4,
    S_WON   = 3'd5,
    S_LOST  = 3'd6
  } state_t;

  // Codes 26..31 come out of the keyboard decoder for non-letter keys.
  function automatic logic is_legal(input letter_t l);
    return l < LETTER_W'(ALPHA);
  endfunction

  function automatic logic in_round(input state_t s);
    return (s == S_LOAD) || (s == S_PLAY) || (s == S_CHECK) || (s == S_EVAL);
  endfunction

endpackage

// File: rtl/hangman_round_ctrl_if.sv
// Guess handshake from the letter-decode front end plus the per-guess result pulses.
interface hangman_round_ctrl_if;
  import hangman_pkg::*;

  // A guess transfers on a rising clk edge where guess_valid && guess_ready are both 1.
  // guess_ready depends only on controller state, never on guess_valid; a guess offered
  // while guess_ready=0 is dropped, not held, so the source must keep valid up to acceptance.
  logic    guess_valid;
  letter_t guess_letter;
  logic    guess_ready;

  logic    hit;
  logic    miss;
  logic    repeat_guess;
  logic    bad_guess;

  modport master (
    output guess_valid,
    output guess_letter,
    input  guess_ready,
    input  hit,
    input  miss,
    input  repeat_guess,
    input  bad_guess
  );

  modport slave (
    input  guess_valid,
    input  guess_letter,
    output guess_ready,
    output hit,
    output miss,
    output repeat_guess,
    output bad_guess
  );

endinterface

// File: rtl/hangman_letter_tracker.sv
// Round storage: secret word set, guessed-letter mask and saturating miss counter.
module hangman_letter_tracker
  import hangman_pkg::*;
#(
  parameter  int MAX_MISSES = 6,
  localparam int MISS_W     = $clog2(MAX_MISSES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              update,
  input  logic [ALPHA-1:0]  word_letters,
  input  letter_t           letter,
  output logic [ALPHA-1:0]  word,
  output logic [ALPHA-1:0]  guessed_mask,
  output logic [MISS_W-1:0] misses,
  output logic              letter_seen,
  output logic              letter_in_word,
  output logic              all_found,
  output logic              out_of_misses
);

  always_ff @(posedge clk) begin
    if (reset) begin
      word         <= '0;
      guessed_mask <= '0;
      misses       <= '0;
    end else begin
      if (load) begin
        word <= word_letters;
      end
      if (clear) begin
        guessed_mask <= '0;
        misses       <= '0;
      end else if (update && !letter_seen) begin
        guessed_mask[letter] <= 1'b1;
        // Guard keeps the counter pinned at MAX_MISSES even if a guess sneaks past.
        if (!letter_in_word && !out_of_misses) begin
          misses <= misses + MISS_W'(1);
        end
      end
    end
  end

  assign letter_seen    = guessed_mask[letter];
  assign letter_in_word = word[letter];
  assign all_found      = ((guessed_mask | ~word) == ALL_LETTERS);
  assign out_of_misses  = (misses == MISS_W'(MAX_MISSES));

endmodule

// File: rtl/hangman_round_ctrl.sv
// Round sequencer: loads the word, accepts one guess per PLAY visit, grades it and decides win/loss.
module hangman_round_ctrl
  import hangman_pkg::*;
#(
  parameter  int MAX_MISSES = 6,
  localparam int MISS_W     = $clog2(MAX_MISSES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ALPHA-1:0]     word_letters,
  hangman_round_ctrl_if.slave  guess_if,
  output logic [ALPHA-1:0]     guessed_mask,
  output logic [ALPHA-1:0]     revealed_mask,
  output logic [MISS_W-1:0]    misses_left,
  output logic                 game_won,
  output logic                 game_lost,
  output logic                 busy,
  output state_t               dbg_state
);

  state_t state;
  state_t state_nxt;

  logic trk_clear;
  logic trk_load;
  logic trk_update;

  letter_t          letter_q;
  logic [ALPHA-1:0] word;
  logic [MISS_W-1:0] misses;
  logic letter_seen;
  logic letter_in_word;
  logic all_found;
  logic out_of_misses;

  logic guess_take;
  logic guess_reject;

  logic hit_q;
  logic miss_q;
  logic repeat_q;
  logic bad_q;
  logic won_q;
  logic lost_q;

  assign guess_if.guess_ready = (state == S_PLAY);
  assign guess_take   = guess_if.guess_valid && guess_if.guess_ready &&  is_legal(guess_if.guess_letter);
  assign guess_reject = guess_if.guess_valid && guess_if.guess_ready && !is_legal(guess_if.guess_letter);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    trk_clear  = 1'b0;
    trk_load   = 1'b0;
    trk_update = 1'b0;
    case (state)
      S_IDLE, S_WON, S_LOST: begin
        // An empty word would be won on the spot, so such a start is treated as noise.
        if (start && (word_letters != '0)) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        trk_clear = 1'b1;
        trk_load  = 1'b1;
        state_nxt = S_PLAY;
      end
      S_PLAY: begin
        if (guess_take) begin
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        trk_update = 1'b1;
        state_nxt  = S_EVAL;
      end
      S_EVAL: begin
        if (all_found) begin
          state_nxt = S_WON;
        end else if (out_of_misses) begin
          state_nxt = S_LOST;
        end else begin
          state_nxt = S_PLAY;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      letter_q <= '0;
    end else if (guess_take) begin
      letter_q <= guess_if.guess_letter;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      repeat_q <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      hit_q    <= (state == S_CHECK) && !letter_seen &&  letter_in_word;
      miss_q   <= (state == S_CHECK) && !letter_seen && !letter_in_word;
      repeat_q <= (state == S_CHECK) &&  letter_seen;
      bad_q    <= guess_reject;
    end
  end

  // Win is evaluated first so a final guess that completes the word never loses.
  always_ff @(posedge clk) begin
    if (reset) begin
      won_q  <= 1'b0;
      lost_q <= 1'b0;
    end else if (state == S_LOAD) begin
      won_q  <= 1'b0;
      lost_q <= 1'b0;
    end else if (state == S_EVAL) begin
      won_q  <= all_found;
      lost_q <= !all_found && out_of_misses;
    end
  end

  hangman_letter_tracker #(
    .MAX_MISSES (MAX_MISSES)
  ) u_tracker (
    .clk            (clk),
    .reset          (reset),
    .clear          (trk_clear),
    .load           (trk_load),
    .update         (trk_update),
    .word_letters   (word_letters),
    .letter         (letter_q),
    .word           (word),
    .guessed_mask   (guessed_mask),
    .misses         (misses),
    .letter_seen    (letter_seen),
    .letter_in_word (letter_in_word),
    .all_found      (all_found),
    .out_of_misses  (out_of_misses)
  );

  assign guess_if.hit          = hit_q;
  assign guess_if.miss         = miss_q;
  assign guess_if.repeat_guess = repeat_q;
  assign guess_if.bad_guess    = bad_q;

  assign revealed_mask = guessed_mask & word;
  assign misses_left   = MISS_W'(MAX_MISSES) - misses;
  assign game_won      = won_q;
  assign game_lost     = lost_q;
  assign busy          = in_round(state);
  assign dbg_state     = state;

endmodule

// File: tb/tb_hangman_round_ctrl.sv
// Directed bench for hangman_round_ctrl: per-cycle model comparison plus literal checks of each scenario.
module tb_hangman_round_ctrl;
  import hangman_pkg::*;

  localparam int MAXM = 6;
  localparam int MW   = $clog2(MAXM + 1);

  localparam logic [3:0] P_HIT  = 4'b1000;
  localparam logic [3:0] P_MISS = 4'b0100;
  localparam logic [3:0] P_REP  = 4'b0010;
  localparam logic [3:0] P_BAD  = 4'b0001;

  // ---------------- clock / reset / DUT ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [ALPHA-1:0] word_letters = '0;
  logic [ALPHA-1:0] guessed_mask;
  logic [ALPHA-1:0] revealed_mask;
  logic [MW-1:0]    misses_left;
  logic             game_won;
  logic             game_lost;
  logic             busy;
  state_t           dbg_state;

  hangman_round_ctrl_if gif();

  hangman_round_ctrl #(.MAX_MISSES(MAXM)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .word_letters  (word_letters),
    .guess_if      (gif),
    .guessed_mask  (guessed_mask),
    .revealed_mask (revealed_mask),
    .misses_left   (misses_left),
    .game_won      (game_won),
    .game_lost     (game_lost),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // Second instance with a single allowed miss for the win-priority case.
  logic             start1 = 1'b0;
  logic [ALPHA-1:0] word1 = '0;
  logic [ALPHA-1:0] gm1;
  logic [ALPHA-1:0] rm1;
  logic [0:0]       ml1;
  logic             won1;
  logic             lost1;
  logic             busy1;
  state_t           st1;

  hangman_round_ctrl_if gif1();

  hangman_round_ctrl #(.MAX_MISSES(1)) dut1 (
    .clk           (clk),
    .reset         (reset),
    .start         (start1),
    .word_letters  (word1),
    .guess_if      (gif1),
    .guessed_mask  (gm1),
    .revealed_mask (rm1),
    .misses_left   (ml1),
    .game_won      (won1),
    .game_lost     (lost1),
    .busy          (busy1),
    .dbg_state     (st1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of dut ----------------
  logic [ALPHA-1:0] m_word = '0;
  logic [ALPHA-1:0] m_guessed = '0;
  int  m_misses = 0;
  int  m_letter = 0;
  bit  m_won, m_lost, m_active, m_ready, m_loading, m_check, m_decide, m_live;
  bit  m_hit, m_miss, m_rep, m_bad;

  task automatic model_step();
    m_hit = 0; m_miss = 0; m_rep = 0; m_bad = 0;
    if (reset) begin
      m_word = '0; m_guessed = '0; m_misses = 0;
      m_won = 0; m_lost = 0; m_active = 0; m_ready = 0;
      m_loading = 0; m_check = 0; m_decide = 0; m_live = 1;
      return;
    end
    if (m_loading) begin
      m_word = word_letters; m_guessed = '0; m_misses = 0;
      m_won = 0; m_lost = 0; m_loading = 0; m_ready = 1;
    end else if (m_check) begin
      m_check = 0; m_decide = 1;
      if (m_guessed[m_letter]) m_rep = 1;
      else begin
        m_guessed[m_letter] = 1'b1;
        if (m_word[m_letter]) m_hit = 1;
        else begin m_miss = 1; m_misses++; end
      end
    end else if (m_decide) begin
      m_decide = 0;
      if ((m_word & ~m_guessed) == '0) begin m_won = 1; m_active = 0; end
      else if (m_misses == MAXM) begin m_lost = 1; m_active = 0; end
      else m_ready = 1;
    end else if (m_ready) begin
      if (gif.guess_valid) begin
        if (gif.guess_letter > 5'd25) m_bad = 1;
        else begin m_letter = int'(gif.guess_letter); m_ready = 0; m_check = 1; end
      end
    end else if (!m_active && start && (word_letters != '0)) begin
      m_active = 1; m_loading = 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: every cycle once reset has been seen.
  initial forever begin
    logic [3:0] pulses;
    logic [ALPHA-1:0] m_rev;
    @(negedge clk);
    if (m_live) begin
      m_rev = '0;
      for (int i = 0; i < ALPHA; i++) if (m_word[i] && m_guessed[i]) m_rev[i] = 1'b1;
      pulses = {gif.hit, gif.miss, gif.repeat_guess, gif.bad_guess};
      check("cyc_ready", gif.guess_ready, m_ready);
      check("cyc_busy", busy, m_active);
      check("cyc_pulses", pulses, {m_hit, m_miss, m_rep, m_bad});
      check("cyc_won", game_won, m_won);
      check("cyc_lost", game_lost, m_lost);
      check("cyc_misses_left", misses_left, MAXM - m_misses);
      check("cyc_guessed", guessed_mask, m_guessed);
      check("cyc_revealed", revealed_mask, m_rev);
      if (pulses != 4'b0000) begin
        if (exp_q.size() == 0) check("pulse_unexpected", pulses, 4'b0000);
        else check("pulse_order", pulses, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string name);
    int n = 0;
    while (!gif.guess_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, gif.guess_ready, 1);
  endtask

  task automatic start_round(input logic [ALPHA-1:0] w);
    start = 1'b1; word_letters = w;
    @(negedge clk);
    start = 1'b0;
    check("busy_in_load", busy, 1);
    @(negedge clk);
    wait_ready("start_ready");
  endtask

  task automatic guess(input logic [4:0] l, input logic [3:0] code);
    wait_ready("guess_ready_wait");
    exp_q.push_back(code);
    gif.guess_valid = 1'b1; gif.guess_letter = l;
    @(negedge clk);
    gif.guess_valid = 1'b0;
    if (code == P_BAD) begin
      check("bad_pulse_n1", gif.bad_guess, 1);
      check("bad_stays_play", dbg_state, S_PLAY);
    end else begin
      check("check_not_ready", gif.guess_ready, 0);
      @(negedge clk);
      check("pulse_at_n2", {gif.hit, gif.miss, gif.repeat_guess, gif.bad_guess}, code);
      @(negedge clk);
    end
  endtask

  task automatic guess1(input logic [4:0] l);
    gif1.guess_valid = 1'b1; gif1.guess_letter = l;
    @(negedge clk);
    gif1.guess_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    gif.guess_valid = 1'b0; gif.guess_letter = '0;
    gif1.guess_valid = 1'b0; gif1.guess_letter = '0;
    repeat (3) @(negedge clk);
    check("rst_state", dbg_state, S_IDLE);
    check("rst_misses_left", misses_left, 6);
    check("rst_guessed", guessed_mask, 0);
    check("rst_flags", {game_won, game_lost, busy, gif.guess_ready}, 4'b0000);
    reset = 1'b0;
    @(negedge clk);

    // Win path: A,B,C.
    start_round(26'h7);
    guess(5'd0, P_HIT);
    guess(5'd1, P_HIT);
    guess(5'd2, P_HIT);
    check("win_won", game_won, 1);
    check("win_misses_left", misses_left, 6);
    check("win_revealed", revealed_mask, 26'h7);
    check("win_not_ready", gif.guess_ready, 0);
    check("win_state", dbg_state, S_WON);

    // Empty-word start in WON is ignored.
    start = 1'b1; word_letters = '0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("empty_start_won_held", game_won, 1);
    check("empty_start_state", dbg_state, S_WON);

    // Loss path: word A only, six misses.
    start_round(26'h1);
    check("loss_cleared_won", game_won, 0);
    for (int i = 0; i < 6; i++) begin
      logic [4:0] l;
      l = 5'(25 - i);
      guess(l, P_MISS);
      check("loss_misses_left", misses_left, 5 - i);
    end
    check("loss_lost", game_lost, 1);
    check("loss_not_ready", gif.guess_ready, 0);
    check("loss_state", dbg_state, S_LOST);

    // Restart from LOST, then repeat and illegal guesses.
    start_round(26'h3);
    check("restart_lost_clear", game_lost, 0);
    check("restart_mask_clear", guessed_mask, 0);
    check("restart_misses_left", misses_left, 6);
    guess(5'd0, P_HIT);
    guess(5'd0, P_REP);
    check("repeat_no_penalty", misses_left, 6);
    guess(5'd26, P_BAD);
    guess(5'd30, P_BAD);
    check("bad_mask_kept", guessed_mask, 26'h1);
    check("bad_state_play", dbg_state, S_PLAY);

    // Start during PLAY is ignored.
    start = 1'b1; word_letters = 26'h3FF;
    @(negedge clk);
    start = 1'b0; word_letters = 26'h3;
    repeat (2) @(negedge clk);
    check("midstart_state", dbg_state, S_PLAY);
    check("midstart_mask", guessed_mask, 26'h1);
    guess(5'd1, P_HIT);
    check("midstart_then_win", game_won, 1);

    // Reset during CHECK: no pulse, everything back to reset values.
    start_round(26'h5);
    gif.guess_valid = 1'b1; gif.guess_letter = 5'd3;
    @(negedge clk);
    gif.guess_valid = 1'b0;
    check("in_check", dbg_state, S_CHECK);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_state", dbg_state, S_IDLE);
    check("midrst_pulses", {gif.hit, gif.miss, gif.repeat_guess, gif.bad_guess}, 4'b0000);
    check("midrst_misses_left", misses_left, 6);
    check("midrst_flags", {game_won, game_lost, busy, gif.guess_ready}, 4'b0000);
    reset = 1'b0;
    @(negedge clk);

    // Guess offered while idle is dropped, not queued.
    gif.guess_valid = 1'b1; gif.guess_letter = 5'd0;
    repeat (3) @(negedge clk);
    gif.guess_valid = 1'b0;
    check("idle_guess_ignored", guessed_mask, 0);
    start_round(26'h1);
    check("no_queued_guess", guessed_mask, 0);
    guess(5'd0, P_HIT);
    check("single_letter_win", game_won, 1);
    check("single_letter_revealed", revealed_mask, 26'h1);

    // MAX_MISSES=1 instance: loss on first miss, then win priority with one miss left.
    start1 = 1'b1; word1 = 26'h2;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    check("m1_ready", gif1.guess_ready, 1);
    guess1(5'd0);
    check("m1_miss_pulse", {gif1.hit, gif1.miss}, 2'b01);
    @(negedge clk);
    check("m1_lost", {won1, lost1}, 2'b01);
    check("m1_misses_left0", ml1, 0);
    check("m1_not_ready", gif1.guess_ready, 0);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    check("m1_restart_clear", {lost1, gm1[1:0]}, 3'b000);
    guess1(5'd1);
    check("m1_hit_pulse", {gif1.hit, gif1.miss}, 2'b10);
    @(negedge clk);
    check("m1_won", {won1, lost1}, 2'b10);
    check("m1_misses_left1", ml1, 1);
    check("m1_revealed", rm1, 26'h2);
    check("m1_busy", busy1, 0);
    check("m1_state", st1, S_WON);

    repeat (2) @(negedge clk);
    check("pulse_queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
